seg_scan_display: RTL and testbench

Three-digit multiplexed seven-segment driver that consumes the stopwatch/countdown Timer's digit outputs (`tens`, `ones`, `xiaoshu`, `point`, `led`) and drives a common-anode display. It sits between the Timer and the board's segment/digit-select pins. It time-multiplexes the digits, snapshots the inputs once per frame to avoid tearing, suppresses a leading zero, and flashes the whole display while the Timer's `led` (countdown done) is asserted.

---
 rtl/seg_scan_display_if.sv | 14 +
 rtl/seg_scan_display.sv | 146 ++++++++++++++
 tb/tb_seg_scan_display.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// Timer-to-display bundle: digit data and flags in, segment/digit-select pins out.
interface seg_scan_display_if;
    logic       en;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] xiaoshu;
    logic       point;
    logic       led;
    logic [7:0] seg;
    logic [2:0] sel;

    modport master (output en, tens, ones, xiaoshu, point, led, input seg, sel);
    modport slave  (input en, tens, ones, xiaoshu, point, led, output seg, sel);
endinterface

// File: rtl/seg_scan_display.sv
// Three-digit multiplexed common-anode seven-segment driver with per-frame
// snapshot, leading-zero suppression and alarm blink.
module seg_scan_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 50
) (
    input logic               clk,
    input logic               rst_n,
    seg_scan_display_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);
    localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] c_q, c_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] f_q, f_d;
    logic          ph_q, ph_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d, xs_q, xs_d;
    logic          point_q, point_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    sel_q, sel_d;

    logic       slot_end, frame_end, lit, blank, dp;
    logic [3:0] val;
    logic [7:0] digit_seg;

    function automatic logic [7:0] decode(input logic [3:0] v);
        case (v)
            4'd0: decode = 8'hC0;
            4'd1: decode = 8'hF9;
            4'd2: decode = 8'hA4;
            4'd3: decode = 8'hB0;
            4'd4: decode = 8'h99;
            4'd5: decode = 8'h92;
            4'd6: decode = 8'h82;
            4'd7: decode = 8'hF8;
            4'd8: decode = 8'h80;
            4'd9: decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    assign slot_end  = (c_q == C_LAST);
    assign frame_end = bus.en && slot_end && (idx_q == 2'd2);
    assign lit       = bus.en && ph_q && (c_q >= C_BLANK);

    always_comb begin
        c_d     = c_q;
        idx_d   = idx_q;
        f_d     = f_q;
        ph_d    = ph_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        xs_d    = xs_q;
        point_d = point_q;
        blank   = 1'b0;
        dp      = 1'b0;
        val     = 4'd0;

        if (!bus.en) begin
            c_d   = '0;
            idx_d = 2'd0;
        end else if (slot_end) begin
            c_d   = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            c_d = c_q + 1'b1;
        end

        // A falling led (or disabled display) clears the blink state even on a frame end.
        if (!bus.en || !bus.led) begin
            f_d  = '0;
            ph_d = 1'b1;
        end else if (frame_end) begin
            if (f_q == F_LAST) begin
                f_d  = '0;
                ph_d = ~ph_q;
            end else begin
                f_d = f_q + 1'b1;
            end
        end

        if (frame_end || !bus.en) begin
            tens_d  = bus.tens;
            ones_d  = bus.ones;
            xs_d    = bus.xiaoshu;
            point_d = bus.point;
        end

        case (idx_q)
            2'd0: begin
                val   = tens_q;
                blank = (tens_q == 4'd0);
            end
            2'd1: begin
                val = ones_q;
                dp  = point_q;
            end
            default: begin
                val   = xs_q;
                blank = !point_q;
            end
        endcase
        digit_seg = blank ? 8'hFF : (decode(val) & {~dp, 7'h7F});
        seg_d     = lit ? digit_seg : 8'hFF;
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sel
            assign sel_d[gi] = !(lit && (idx_q == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            idx_q   <= 2'd0;
            f_q     <= '0;
            ph_q    <= 1'b1;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            xs_q    <= 4'd0;
            point_q <= 1'b0;
            seg_q   <= 8'hFF;
            sel_q   <= 3'b111;
        end else begin
            c_q     <= c_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            ph_q    <= ph_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            xs_q    <= xs_d;
            point_q <= point_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.sel = sel_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
module tb_seg_scan_display;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    logic [10:0] exp;

    seg_scan_display_if bus ();

    seg_scan_display #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] DARK = {3'b111, 8'hFF};

    // Expected {sel,seg} k cycles after en rose: each slot is 1 dark + 3 lit cycles.
    function automatic logic [10:0] exp_out(input int kk, input logic [7:0] d0, d1, d2);
        int r, slot;
        logic [2:0] s;
        logic [7:0] d;
        r    = (kk - 1) % 4;
        slot = ((kk - 1) / 4) % 3;
        if (r == 0) return DARK;
        s = 3'b111;
        s[slot] = 1'b0;
        d = (slot == 0) ? d0 : (slot == 1) ? d1 : d2;
        return {s, d};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$onehot0(~bus.sel)) begin
            $display("FAIL onehot sel=%b required at most one low bit", bus.sel);
            errors++;
        end
    end

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.led = 1'b0; bus.point = 1'b0;
        bus.tens = 4'd0; bus.ones = 4'd0; bus.xiaoshu = 4'd0;
        step(); step();
        checks++;
        if ({bus.sel, bus.seg} !== DARK) begin
            $display("FAIL reset sel/seg=%b/%h required 111/ff", bus.sel, bus.seg);
            errors++;
        end
        rst_n = 1'b1;
        bus.tens = 4'd1; bus.ones = 4'd5; bus.xiaoshu = 4'd9;
        step(); step();
        checks++;
        if ({bus.sel, bus.seg} !== DARK) begin
            $display("FAIL disabled sel/seg=%b/%h required 111/ff", bus.sel, bus.seg);
            errors++;
        end
        bus.en = 1'b1;
        k = 0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 12; i++) begin
            step();
            exp = exp_out(k, 8'hF9, 8'h92, 8'hFF);
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL scan k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
        end
    endtask

    task automatic test_snapshot();
        bus.tens = 4'd0; bus.ones = 4'd7; bus.xiaoshu = 4'd3; bus.point = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            exp = (k <= 24) ? exp_out(k, 8'hF9, 8'h92, 8'hFF) : exp_out(k, 8'hFF, 8'h78, 8'hB0);
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL snapshot k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
        end
    endtask

    task automatic test_hold();
        bus.tens = 4'd1; bus.ones = 4'd5; bus.xiaoshu = 4'd3; bus.point = 1'b0;
        for (int i = 0; i < 36; i++) begin
            step();
            if (k <= 48)      exp = exp_out(k, 8'hFF, 8'h78, 8'hB0);
            else if (k <= 60) exp = exp_out(k, 8'hF9, 8'h92, 8'hFF);
            else              exp = exp_out(k, 8'hF9, 8'h82, 8'hFF);
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL hold k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
            if (k == 54) bus.ones = 4'd6;
        end
    endtask

    task automatic test_blink();
        bus.led = 1'b1;
        while (k < 148) begin
            step();
            exp = exp_out(k, 8'hF9, 8'h82, 8'hFF);
            if ((k >= 97 && k <= 120) || k >= 145) exp = DARK;
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL blink k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
        end
        bus.led = 1'b0;
        while (k < 152) begin
            step();
            exp = (k == 149) ? DARK : exp_out(k, 8'hF9, 8'h82, 8'hFF);
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL led_drop k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
        end
    endtask

    task automatic test_enable_dash();
        bus.en = 1'b0;
        bus.tens = 4'd12;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.sel, bus.seg} !== DARK) begin
                $display("FAIL en_off cycle=%0d sel/seg=%b/%h required 111/ff", i, bus.sel, bus.seg);
                errors++;
            end
        end
        bus.en = 1'b1;
        k = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            exp = exp_out(k, 8'hBF, 8'h82, 8'hFF);
            checks++;
            if ({bus.sel, bus.seg} !== exp) begin
                $display("FAIL dash k=%0d sel/seg=%b/%h required %b/%h", k, bus.sel, bus.seg, exp[10:8], exp[7:0]);
                errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sel, bus.seg} !== DARK) begin
            $display("FAIL async_reset sel/seg=%b/%h required 111/ff", bus.sel, bus.seg);
            errors++;
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.sel, bus.seg} !== DARK) begin
            $display("FAIL post_reset sel/seg=%b/%h required 111/ff", bus.sel, bus.seg);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_hold();
        test_blink();
        test_enable_dash();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
